// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter: grants one master at a time, never breaks a
// fixed-length burst or a locked sequence, and drives the address/data-phase owner indices.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTER = 4,
  parameter int unsigned MASTER_W   = 2,
  parameter int unsigned DEF_MASTER = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_MASTER-1:0] hbusreq_i,
  input  logic [NUM_MASTER-1:0] hlock_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hburst_i,
  input  logic                  hready_i,
  output logic [NUM_MASTER-1:0] hgrant_o,
  output logic [MASTER_W-1:0]   hmaster_o,
  output logic [MASTER_W-1:0]   hmaster_data_o,
  output logic                  hmastlock_o
);

  localparam int unsigned BEAT_W = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [MASTER_W-1:0] DEF_IDX = MASTER_W'(DEF_MASTER);

  logic [BEAT_W-1:0]   beats_left;
  logic [BEAT_W-1:0]   beats_next;
  logic [MASTER_W-1:0] grant_idx;
  logic [MASTER_W-1:0] grant_next;
  logic [MASTER_W-1:0] last_winner;
  logic [MASTER_W-1:0] last_next;
  logic [MASTER_W-1:0] cand;
  logic [MASTER_W-1:0] winner_idx;
  logic                winner_found;
  logic                arb_allowed;

  // Remaining beats of the current fixed-length burst after this edge.
  always_comb begin
    beats_next = beats_left;
    if (hready_i) begin
      unique case (htrans_i)
        HTRANS_NONSEQ: begin
          unique case (hburst_i)
            3'b010, 3'b011: beats_next = BEAT_W'(3);
            3'b100, 3'b101: beats_next = BEAT_W'(7);
            3'b110, 3'b111: beats_next = BEAT_W'(15);
            default:        beats_next = '0;
          endcase
        end
        HTRANS_SEQ:  beats_next = (beats_left == '0) ? '0 : beats_left - BEAT_W'(1);
        HTRANS_IDLE: beats_next = '0;
        HTRANS_BUSY: beats_next = beats_left;
        default:     beats_next = beats_left;
      endcase
    end
  end

  assign arb_allowed = hready_i && (beats_next == '0) && !hlock_i[grant_idx] &&
                       (htrans_i != HTRANS_BUSY);

  // Round-robin search starting just after the last winner.
  always_comb begin
    cand         = '0;
    winner_found = 1'b0;
    winner_idx   = DEF_IDX;
    for (int unsigned i = 1; i <= NUM_MASTER; i++) begin
      cand = MASTER_W'((32'(last_winner) + i) % NUM_MASTER);
      if (!winner_found && hbusreq_i[cand]) begin
        winner_found = 1'b1;
        winner_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_next = grant_idx;
    last_next  = last_winner;
    if (arb_allowed) begin
      grant_next = winner_found ? winner_idx : DEF_IDX;
      last_next  = winner_found ? winner_idx : last_winner;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      beats_left     <= '0;
      grant_idx      <= DEF_IDX;
      last_winner    <= DEF_IDX;
      hgrant_o       <= NUM_MASTER'(1) << DEF_IDX;
      hmaster_o      <= DEF_IDX;
      hmaster_data_o <= DEF_IDX;
      hmastlock_o    <= 1'b0;
    end else begin
      beats_left  <= beats_next;
      grant_idx   <= grant_next;
      last_winner <= last_next;
      hgrant_o    <= NUM_MASTER'(1) << grant_next;
      // Pipeline handover: grant -> address phase -> data phase.
      if (hready_i) begin
        hmaster_o      <= grant_idx;
        hmaster_data_o <= hmaster_o;
        hmastlock_o    <= hlock_i[hmaster_o];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter with four masters, park master 0.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_WRAP8  = 3'b100;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq_i;
  logic [3:0] hlock_i;
  logic [1:0] htrans_i;
  logic [2:0] hburst_i;
  logic       hready_i;
  logic [3:0] hgrant_o;
  logic [1:0] hmaster_o;
  logic [1:0] hmaster_data_o;
  logic       hmastlock_o;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NUM_MASTER(4), .MASTER_W(2), .DEF_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq_i(hbusreq_i), .hlock_i(hlock_i),
    .htrans_i(htrans_i), .hburst_i(hburst_i), .hready_i(hready_i),
    .hgrant_o(hgrant_o), .hmaster_o(hmaster_o), .hmaster_data_o(hmaster_data_o),
    .hmastlock_o(hmastlock_o)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    hbusreq_i = '0; hlock_i = '0; htrans_i = T_IDLE; hburst_i = B_SINGLE; hready_i = 1'b1;
    step();
    hreset = 1'b0;
  endtask

  // Master 1 granted then owning the address phase (hmaster_o = 1).
  task automatic own_master1();
    do_reset();
    hbusreq_i = 4'b0010;
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hgrant_o !== 4'b0001 || hmaster_o !== 2'd0 || hmaster_data_o !== 2'd0 || hmastlock_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got grant=%b m=%0d d=%0d lock=%b, expected 0001 0 0 0",
               hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o);
    end
    own_master1();
    hlock_i = 4'b0010; htrans_i = T_NONSEQ; hburst_i = B_INCR8;
    step();
    htrans_i = T_SEQ;
    step();
    step();
    checks++;
    if (hgrant_o !== 4'b0010 || hmaster_o !== 2'd1 || hmaster_data_o !== 2'd1 || hmastlock_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_burst: got grant=%b m=%0d d=%0d lock=%b, expected 0010 1 1 1",
               hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o);
    end
    #2 hreset = 1'b1;
    #1;
    checks++;
    if (hgrant_o !== 4'b0001 || hmaster_o !== 2'd0 || hmaster_data_o !== 2'd0 || hmastlock_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got grant=%b m=%0d d=%0d lock=%b, expected 0001 0 0 0",
               hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o);
    end
    hreset = 1'b0; hlock_i = '0; htrans_i = T_IDLE; hburst_i = B_SINGLE; hbusreq_i = 4'b1111;
    step();
    checks++;
    if (hgrant_o !== 4'b0010) begin
      errors++;
      $display("FAIL resume_from_park: got grant=%b expected 0010", hgrant_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int eg, em, ed;
    do_reset();
    hbusreq_i = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      step();
      eg = k % 4;
      em = (k - 1) % 4;
      ed = (k >= 2) ? (k - 2) % 4 : 0;
      exp_g = 4'b0001 << eg;
      checks++;
      if (hgrant_o !== exp_g) begin
        errors++;
        $display("FAIL rr_grant edge%0d: got %b expected %b", k, hgrant_o, exp_g);
      end
      checks++;
      if (hmaster_o !== 2'(em) || hmaster_data_o !== 2'(ed)) begin
        errors++;
        $display("FAIL rr_master edge%0d: got m=%0d d=%0d expected m=%0d d=%0d",
                 k, hmaster_o, hmaster_data_o, em, ed);
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_g;
    own_master1();
    hbusreq_i = 4'b0110; hburst_i = B_INCR4;
    for (int beat = 1; beat <= 4; beat++) begin
      htrans_i = (beat == 1) ? T_NONSEQ : T_SEQ;
      step();
      exp_g = (beat < 4) ? 4'b0010 : 4'b0100;
      checks++;
      if (hgrant_o !== exp_g) begin
        errors++;
        $display("FAIL burst_grant beat%0d: got %b expected %b", beat, hgrant_o, exp_g);
      end
    end
    htrans_i = T_IDLE;
  endtask

  task automatic test_wait_states();
    logic [3:0] exp_g;
    own_master1();
    hbusreq_i = 4'b0110; hburst_i = B_WRAP8;
    for (int e = 1; e <= 11; e++) begin
      htrans_i = (e == 1) ? T_NONSEQ : T_SEQ;
      hready_i = !(e >= 5 && e <= 7);
      hlock_i  = (e >= 5 && e <= 7) ? 4'b0010 : 4'b0000;
      step();
      exp_g = (e < 11) ? 4'b0010 : 4'b0100;
      checks++;
      if (hgrant_o !== exp_g) begin
        errors++;
        $display("FAIL wait_grant cycle%0d: got %b expected %b", e, hgrant_o, exp_g);
      end
      if (e >= 5 && e <= 7) begin
        checks++;
        if (hmaster_o !== 2'd1 || hmaster_data_o !== 2'd1 || hmastlock_o !== 1'b0) begin
          errors++;
          $display("FAIL wait_freeze cycle%0d: got m=%0d d=%0d lock=%b expected 1 1 0",
                   e, hmaster_o, hmaster_data_o, hmastlock_o);
        end
      end
    end
    hready_i = 1'b1; htrans_i = T_IDLE;
  endtask

  task automatic test_lock();
    logic [3:0] exp_g;
    logic       exp_l;
    do_reset();
    hbusreq_i = 4'b0100; hlock_i = 4'b0100;
    step();
    checks++;
    if (hgrant_o !== 4'b0100) begin
      errors++;
      $display("FAIL lock_first_grant: got %b expected 0100", hgrant_o);
    end
    hbusreq_i = 4'b1111; htrans_i = T_NONSEQ; hburst_i = B_SINGLE;
    for (int e = 2; e <= 5; e++) begin
      if (e == 5) begin
        hlock_i = 4'b0000; htrans_i = T_IDLE;
      end
      step();
      exp_g = (e < 5) ? 4'b0100 : 4'b1000;
      exp_l = (e == 3 || e == 4);
      checks++;
      if (hgrant_o !== exp_g || hmastlock_o !== exp_l) begin
        errors++;
        $display("FAIL lock_hold edge%0d: got grant=%b lock=%b expected %b %b",
                 e, hgrant_o, hmastlock_o, exp_g, exp_l);
      end
    end
  endtask

  task automatic test_parking();
    logic [3:0] req_seq [5];
    logic [3:0] exp_seq [5];
    do_reset();
    req_seq = '{4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b1000};
    exp_seq = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      hbusreq_i = req_seq[i];
      step();
      checks++;
      if (hgrant_o !== exp_seq[i]) begin
        errors++;
        $display("FAIL park_grant step%0d: got %b expected %b", i, hgrant_o, exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_wait_states();
    test_lock();
    test_parking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
